fft_addr_gen: RTL
=================

Name: fft_addr_gen

Overview:
- Schedules one in-place radix-2 DIT FFT pass over an N = 2^LOG2N point complex buffer held in dual-port RAM.
- Each cycle it issues one butterfly:
  - read addresses A and B to the data RAM;
  - twiddle index to the twiddle ROM, which drives butterfly_unit.
- A matching write-back strobe and addresses are delayed by the RAM read latency plus the butterfly pipeline latency, so results land in place.
- Sits directly upstream of butterfly_unit. Input data is already bit-reversed; output is natural order.

Parameters:
- LOG2N, 4, log2 of FFT length (N = 16); legal range 2..10.
- RD_LAT, 1, data RAM and twiddle ROM read latency in cycles.
- BFLY_LAT, 2, butterfly_unit input-to-output latency in cycles (multiplier register + adder register).

Ports:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous, active-low reset.
- i_start, in, 1, single-cycle request to start a full transform.
- o_busy, out, 1, high while a transform is in progress.
- o_done, out, 1, one-cycle pulse after the final write-back.
- o_stage, out, 4, current stage index s (0..LOG2N-1).
- o_rd_en, out, 1, read strobe for data RAM and twiddle ROM.
- o_rd_addr_a, out, LOG2N, butterfly A address.
- o_rd_addr_b, out, LOG2N, butterfly B address.
- o_tw_idx, out, LOG2N-1, twiddle ROM index.
- o_wr_en, out, 1, write-back strobe.
- o_wr_addr_a, out, LOG2N, write address for butterfly output A.
- o_wr_addr_b, out, LOG2N, write address for butterfly output B.

Behaviour:
- Reset: rst low asynchronously clears FSM to IDLE and clears every output and the delay pipeline to 0. This holds even mid-transform; no partial writes occur after rst asserts.
- All outputs are registered.
- Define L = RD_LAT + BFLY_LAT.
- FSM states: IDLE, ISSUE, FLUSH, DONE.
- IDLE:
  - all strobes low;
  - i_start=1 moves to ISSUE with s=0, k=0.
  - i_start in any non-IDLE state is ignored.
- ISSUE:
  - o_rd_en=1 every cycle, one butterfly per cycle, k = 0..N/2-1.
  - span = 2^s, pos = k mod span, grp = k / span.
  - addr_a = grp*2*span + pos; addr_b = addr_a + span.
  - tw_idx = pos << (LOG2N-1-s).
  - After k = N/2-1, go to FLUSH with flush counter 0.
- FLUSH:
  - o_rd_en=0, lasts exactly L cycles.
  - This guarantees the stage's last write completes before the next stage's first read (no RAW hazard across stages).
  - At the end: if s < LOG2N-1, increment s, reset k, and go to ISSUE; else go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- o_busy=1 in ISSUE, FLUSH and DONE.
- Write-back:
  - o_wr_en, o_wr_addr_a and o_wr_addr_b are o_rd_en, o_rd_addr_a and o_rd_addr_b delayed exactly L cycles through a shift register.
  - Each read issued at cycle t produces exactly one write at t+L. The last write of each stage falls in the final FLUSH cycle.
- o_stage changes only on the ISSUE entry edge.
- Total busy cycles = LOG2N*(N/2 + L) + 1. Default: 4*(8+3)+1 = 45.
- Counter widths: k is LOG2N-1 bits; wrap of k is never used (the FSM exits first). The flush counter is sized for L ≤ 15.

Decomposition:
- Shared package fft_pkg:
  - LOG2N default, FFT_N, HALF_N;
  - FSM state encoding (IDLE=0, ISSUE=1, FLUSH=2, DONE=3);
  - butterfly latency constant, reused by butterfly_unit integration and the top level.
- One sub-module, fft_wb_delay: a parameterised depth-L shift register carrying {valid, addr_a, addr_b}, reset to zero by rst.

Test Plan:
- Reset held low, random i_start → all outputs 0, o_busy=0. Release → stays IDLE until i_start.
- i_start, defaults, stage 0 → rd pairs (0,1),(2,3)..(14,15), tw_idx all 0. First o_wr_en exactly 3 cycles after first o_rd_en with addrs (0,1).
- Stage 1 k=1 → a=1, b=3, tw=4. Stage 2 k=5 → a=9, b=13, tw=2. Stage 3 k=7 → a=7, b=15, tw=7.
- Full run → o_busy high 45 cycles; 32 rd strobes and 32 wr strobes total; o_done pulses once, one cycle after the last o_wr_en. No stage-(s+1) read precedes any stage-s write.
- i_start re-asserted during ISSUE and FLUSH → ignored; count and sequence unchanged.
- rst pulsed low during stage 2 flush → all outputs 0 immediately, no further o_wr_en. A new i_start restarts at stage 0, k=0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the FFT address generator and its
// butterfly_unit integration.
package fft_pkg;

  // Default transform size: N = 2^LOG2N_DEF points.
  localparam int LOG2N_DEF = 4;
  localparam int FFT_N     = 1 << LOG2N_DEF;
  localparam int HALF_N    = FFT_N / 2;

  // Pipeline latencies seen by the write-back path.
  localparam int RD_LAT_DEF   = 1;  // data RAM / twiddle ROM read
  localparam int BFLY_LAT_DEF = 2;  // butterfly_unit: multiplier reg + adder reg

  // Scheduler states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fft_addr_gen_if.sv
// Control and RAM-address bundle between the FFT scheduler and its host/RAMs.
interface fft_addr_gen_if #(
  parameter int LOG2N = 4
);
  logic             i_start;
  logic             o_busy;
  logic             o_done;
  logic [3:0]       o_stage;
  logic             o_rd_en;
  logic [LOG2N-1:0] o_rd_addr_a;
  logic [LOG2N-1:0] o_rd_addr_b;
  logic [LOG2N-2:0] o_tw_idx;
  logic             o_wr_en;
  logic [LOG2N-1:0] o_wr_addr_a;
  logic [LOG2N-1:0] o_wr_addr_b;

  // Host side: requests transforms, observes schedule.
  modport master (
    output i_start,
    input  o_busy, o_done, o_stage,
    input  o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx,
    input  o_wr_en, o_wr_addr_a, o_wr_addr_b
  );

  // Scheduler side.
  modport slave (
    input  i_start,
    output o_busy, o_done, o_stage,
    output o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_idx,
    output o_wr_en, o_wr_addr_a, o_wr_addr_b
  );
endinterface

// File: rtl/fft_wb_delay.sv
// Depth-DEPTH shift register that replays {valid, addr_a, addr_b} as the
// write-back request once the read and butterfly pipelines have drained.
module fft_wb_delay #(
  parameter int DEPTH = 3,
  parameter int W     = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out
);

  // tap[0] is the input; tap[gi+1] is the output of stage gi.
  logic [DEPTH:0][W-1:0] tap;

  assign tap[0] = d_in;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [W-1:0] stage_q;

    // One register per cycle of latency; cleared so no stale write survives reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) stage_q <= '0;
      else      stage_q <= tap[gi];
    end

    assign tap[gi+1] = stage_q;
  end

  assign d_out = tap[DEPTH];

endmodule

// File: rtl/fft_addr_gen.sv
// Radix-2 DIT in-place FFT scheduler: one butterfly read per cycle, with the
// matching write-back delayed by RD_LAT + BFLY_LAT.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N    = LOG2N_DEF,
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int BFLY_LAT = BFLY_LAT_DEF
) (
  input  logic clk,
  input  logic rst,
  fft_addr_gen_if.slave bus
);

  localparam int L  = RD_LAT + BFLY_LAT;   // read-to-write distance, 1..15
  localparam int KW = LOG2N - 1;
  localparam logic [KW-1:0] K_LAST = '1;   // N/2-1
  localparam logic [3:0]    S_LAST = 4'(LOG2N - 1);
  localparam logic [3:0]    F_LAST = 4'(L - 1);

  state_e          state_q, state_d;
  logic [3:0]      s_q, s_d;
  logic [KW-1:0]   k_q, k_d;
  logic [3:0]      f_q, f_d;

  logic             busy_q, done_q, rd_en_q, rd_en_d;
  logic [3:0]       stage_q;
  logic [LOG2N-1:0] rd_a_q, rd_b_q, addr_a_d, addr_b_d;
  logic [LOG2N-2:0] tw_q, tw_d;
  logic [LOG2N-1:0] k_ext, span, pos, grp;

  // Next-state: walk k across each stage, then drain L cycles before the next stage.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    f_d     = f_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d = ST_ISSUE;
          s_d     = '0;
          k_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = ST_FLUSH;
          f_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_FLUSH: begin
        if (f_q == F_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            s_d     = s_q + 4'd1;
            k_d     = '0;
          end
        end else begin
          f_d = f_q + 4'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Butterfly addressing for the butterfly about to be issued (k_d in stage s_d).
  always_comb begin
    k_ext    = {1'b0, k_d};
    span     = LOG2N'(1) << s_d;
    pos      = k_ext & (span - 1'b1);
    grp      = k_ext >> s_d;
    rd_en_d  = (state_d == ST_ISSUE);
    addr_a_d = '0;
    addr_b_d = '0;
    tw_d     = '0;
    if (rd_en_d) begin
      addr_a_d = (grp << (s_d + 4'd1)) | pos;
      addr_b_d = addr_a_d | span;
      tw_d     = (LOG2N-1)'(pos << (S_LAST - s_d));
    end
  end

  // FSM state and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      f_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stage_q <= '0;
      rd_en_q <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      f_q     <= f_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      stage_q <= s_d;
      rd_en_q <= rd_en_d;
      rd_a_q  <= addr_a_d;
      rd_b_q  <= addr_b_d;
      tw_q    <= tw_d;
    end
  end

  logic [2*LOG2N:0] wb_out;

  fft_wb_delay #(
    .DEPTH (L),
    .W     (2*LOG2N + 1)
  ) u_wb_delay (
    .clk   (clk),
    .rst   (rst),
    .d_in  ({rd_en_q, rd_a_q, rd_b_q}),
    .d_out (wb_out)
  );

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_stage     = stage_q;
  assign bus.o_rd_en     = rd_en_q;
  assign bus.o_rd_addr_a = rd_a_q;
  assign bus.o_rd_addr_b = rd_b_q;
  assign bus.o_tw_idx    = tw_q;
  assign bus.o_wr_en     = wb_out[2*LOG2N];
  assign bus.o_wr_addr_a = wb_out[2*LOG2N-1:LOG2N];
  assign bus.o_wr_addr_b = wb_out[LOG2N-1:0];

endmodule
